// File: rtl/swc_wr_pump_pkg.sv
// Shared helpers for the packet-memory write pump: log2 function,
// line-address type and the page-link FSM state encoding.
package swc_wr_pump_pkg;

    function automatic int f_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int c_def_page_addr_width = 10;
    localparam int c_def_lines_per_page  = 8;

    // {page, line} address for the default geometry.
    typedef logic [c_def_page_addr_width+f_log2(c_def_lines_per_page)-1:0] line_addr_t;

    typedef enum logic {
        LL_IDLE = 1'b0,
        LL_REQ  = 1'b1
    } ll_state_t;

endpackage

// File: rtl/swc_wr_pump_ll_ctrl.sv
// Page linked-list write handshake: latches (current page -> next page)
// and holds the request until the linked-list memory acknowledges it.
module swc_wr_pump_ll_ctrl
    import swc_wr_pump_pkg::*;
#(
    parameter int g_page_addr_width = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic [g_page_addr_width-1:0] cur_page_i,
    input  logic [g_page_addr_width-1:0] next_page_i,
    input  logic                         ll_wr_done_i,
    output logic [g_page_addr_width-1:0] ll_addr_o,
    output logic [g_page_addr_width-1:0] ll_data_o,
    output logic                         ll_wr_req_o,
    output logic                         busy_o
);

    ll_state_t state;
    ll_state_t state_next;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= LL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LL_IDLE: if (start_i)      state_next = LL_REQ;
            LL_REQ:  if (ll_wr_done_i) state_next = LL_IDLE;
            default:                   state_next = LL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ll_addr_o <= '0;
            ll_data_o <= '0;
        end else if (state == LL_IDLE && start_i) begin
            ll_addr_o <= cur_page_i;
            ll_data_o <= next_page_i;
        end
    end

    assign ll_wr_req_o = (state == LL_REQ);
    assign busy_o      = (state == LL_REQ);

endmodule

// File: rtl/swc_pkt_mem_write_pump_gen.sv
// Packs ingress words into wide memory lines, double-buffers them and writes
// them in the port's TDM slot. Optional valid-word count: SWC_WRITE_PUMP_VALID_CNT_EN.
module swc_pkt_mem_write_pump_gen
    import swc_wr_pump_pkg::*;
#(
    parameter int g_data_width      = 18,
    parameter int g_ratio           = 16,
    parameter int g_page_addr_width = 10,
    parameter int g_lines_per_page  = 8
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_n_i,
    input  logic [g_data_width-1:0]                                d_i,
    input  logic                                                   drdy_i,
    input  logic                                                   flush_i,
    output logic                                                   full_o,
    input  logic                                                   pckstart_i,
    input  logic [g_page_addr_width-1:0]                           pgaddr_i,
    input  logic                                                   pgreq_i,
    output logic                                                   pgend_o,
    input  logic                                                   sync_i,
    output logic [g_data_width*g_ratio-1:0]                        q_o,
    output logic [g_page_addr_width+f_log2(g_lines_per_page)-1:0]  addr_o,
    output logic                                                   we_o,
`ifdef SWC_WRITE_PUMP_VALID_CNT_EN
    output logic [f_log2(g_ratio):0]                               valid_cnt_o,
`endif
    output logic [g_page_addr_width-1:0]                           ll_addr_o,
    output logic [g_page_addr_width-1:0]                           ll_data_o,
    output logic                                                   ll_wr_req_o,
    input  logic                                                   ll_wr_done_i
);

    localparam int c_idx_w  = f_log2(g_ratio);
    localparam int c_cnt_w  = c_idx_w + 1;
    localparam int c_line_w = f_log2(g_lines_per_page);
    localparam int c_q_w    = g_data_width * g_ratio;

    logic [c_q_w-1:0]             line_q;
    logic [c_q_w-1:0]             line_packed;
    logic [c_cnt_w-1:0]           cnt;
    logic [c_cnt_w-1:0]           cnt_new;
    logic                         in_closed;
    logic [c_q_w-1:0]             buf_q;
    logic                         buf_occ;
`ifdef SWC_WRITE_PUMP_VALID_CNT_EN
    logic [c_cnt_w-1:0]           buf_cnt;
`endif
    logic [g_page_addr_width-1:0] cur_page;
    logic                         page_valid;
    logic [c_line_w-1:0]          line;

    logic accept;
    logic close_now;
    logic line_ready;
    logic do_write;
    logic do_xfer;
    logic buf_occ_next;
    logic in_closed_next;
    logic pg_accept;
    logic ll_start;
    logic ll_busy;

    assign accept         = drdy_i & ~full_o;
    assign cnt_new        = cnt + {{(c_cnt_w-1){1'b0}}, accept};
    assign close_now      = ~in_closed & ((cnt_new == c_cnt_w'(g_ratio)) |
                                          (flush_i & (cnt_new != '0)));
    assign line_ready     = close_now | in_closed;
    assign do_write       = sync_i & buf_occ & page_valid & ~pgend_o & ~ll_busy;
    assign do_xfer        = line_ready & (~buf_occ | do_write);
    assign buf_occ_next   = do_xfer | (buf_occ & ~do_write);
    assign in_closed_next = line_ready & ~do_xfer;
    // Page requests during a pending link write are dropped as protocol errors.
    assign pg_accept      = pgreq_i & ~ll_busy;
    assign ll_start       = pg_accept & ~pckstart_i & page_valid;

    always_comb begin
        line_packed = line_q;
        if (accept) begin
            line_packed[int'(cnt[c_idx_w-1:0]) * g_data_width +: g_data_width] = d_i;
        end
    end

    // Slots are cleared on transfer so a flushed line carries zeros above its last word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            line_q    <= '0;
            cnt       <= '0;
            in_closed <= 1'b0;
            buf_q     <= '0;
            buf_occ   <= 1'b0;
            full_o    <= 1'b0;
`ifdef SWC_WRITE_PUMP_VALID_CNT_EN
            buf_cnt   <= '0;
`endif
        end else begin
            in_closed <= in_closed_next;
            buf_occ   <= buf_occ_next;
            full_o    <= in_closed_next & buf_occ_next;
            if (do_xfer) begin
                buf_q  <= line_packed;
                line_q <= '0;
                cnt    <= '0;
`ifdef SWC_WRITE_PUMP_VALID_CNT_EN
                buf_cnt <= cnt_new;
`endif
            end else begin
                line_q <= line_packed;
                cnt    <= cnt_new;
            end
        end
    end

    // A page request in the same cycle as the last-line write wins over pgend.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_page   <= '0;
            page_valid <= 1'b0;
            line       <= '0;
            pgend_o    <= 1'b0;
        end else if (pg_accept) begin
            cur_page   <= pgaddr_i;
            page_valid <= 1'b1;
            line       <= '0;
            pgend_o    <= 1'b0;
        end else if (do_write) begin
            line <= line + 1'b1;
            if (line == c_line_w'(g_lines_per_page - 1)) begin
                pgend_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_o        <= 1'b0;
            q_o         <= '0;
            addr_o      <= '0;
`ifdef SWC_WRITE_PUMP_VALID_CNT_EN
            valid_cnt_o <= '0;
`endif
        end else begin
            we_o <= do_write;
            if (do_write) begin
                q_o    <= buf_q;
                addr_o <= {cur_page, line};
`ifdef SWC_WRITE_PUMP_VALID_CNT_EN
                valid_cnt_o <= buf_cnt;
`endif
            end
        end
    end

    swc_wr_pump_ll_ctrl #(
        .g_page_addr_width(g_page_addr_width)
    ) u_ll_ctrl (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (ll_start),
        .cur_page_i   (cur_page),
        .next_page_i  (pgaddr_i),
        .ll_wr_done_i (ll_wr_done_i),
        .ll_addr_o    (ll_addr_o),
        .ll_data_o    (ll_data_o),
        .ll_wr_req_o  (ll_wr_req_o),
        .busy_o       (ll_busy)
    );

endmodule

// File: doc/swc_pkt_mem_write_pump_gen.md
# swc_pkt_mem_write_pump_gen

Parametrised write pump for the switch packet memory. It packs narrow ingress words into one wide memory line and double-buffers the line so input can continue while the previous line waits for a write slot. Each line is written in the port's TDM slot (`sync_i`) to the current page at an internally tracked line offset. When a packet crosses a page boundary, the block writes the page link (current page -> next page) to the linked-list memory. It sits between the per-port input block and the shared packet memory / page linked list.

## Interface
- `g_data_width`, 18: ingress word width.
- `g_ratio`, 16: words per memory line; power of 2, ≥2.
- `g_page_addr_width`, 10: page address width.
- `g_lines_per_page`, 8: memory lines per page; power of 2, ≥2.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `d_i` in `g_data_width`: ingress word.
- `drdy_i` in 1: `d_i` valid. Accepted only when `full_o`=0.
- `flush_i` in 1: close the current line early (end of packet).
- `full_o` out 1: back-pressure.
- `pckstart_i` in 1: qualifies `pgreq_i` as the first page of a packet.
- `pgaddr_i` in `g_page_addr_width`: new page address.
- `pgreq_i` in 1: one-cycle strobe loading `pgaddr_i`.
- `pgend_o` out 1: page exhausted; a new page is required.
- `sync_i` in 1: this port's memory write slot.
- `q_o` out `g_data_width*g_ratio`: memory line; slot 0 is in the LSBs.
- `addr_o` out `g_page_addr_width+log2(g_lines_per_page)`: line address, `{page, line}`.
- `we_o` out 1: memory write strobe.
- `ll_addr_o` out `g_page_addr_width`: linked-list address (current page).
- `ll_data_o` out `g_page_addr_width`: linked-list data (next page).
- `ll_wr_req_o` out 1: linked-list write request.
- `ll_wr_done_i` in 1: linked-list write acknowledge.
- `valid_cnt_o` out `log2(g_ratio)+1`: number of valid words in the written line. Present only with the macro (see Configuration).

## Operation
- **Input register.** An accepted word is stored in `slot[cnt]` and `cnt` increments.
- **Closing a line.** The input register closes when `cnt` reaches `g_ratio`, or when `flush_i`=1 with `cnt`>0.
  - If `flush_i` and `drdy_i` are high in the same cycle, the word is stored first and the line then closes including it.
  - `flush_i` with `cnt`=0 and no `drdy_i` is ignored.
- **Transfer to the output buffer.** A closed line moves to the output buffer in the same cycle if the buffer is empty, or in the cycle it empties; `cnt` then returns to 0.
  - Unused slots of a flushed line are zero.
- **Back-pressure.** `full_o` = input register closed AND output buffer occupied.
- **Page state.** `page_valid` is cleared at reset.
  - `pgreq_i` loads `cur_page` = `pgaddr_i`, sets `page_valid` and clears `line`.
  - If `pckstart_i`=0 and `page_valid` was already 1, the request also starts a link write: `ll_addr_o`=old `cur_page`, `ll_data_o`=`pgaddr_i`.
  - If `pckstart_i`=1, no link write is made.
- **Link FSM.** States IDLE, REQ.
  - IDLE->REQ on a link-qualifying `pgreq_i`; `ll_wr_req_o`=1 from the next cycle.
  - REQ holds `ll_wr_req_o`, `ll_addr_o` and `ll_data_o` stable until `ll_wr_done_i`, then returns to IDLE. The request drops in the cycle after done is sampled.
  - A `pgreq_i` while in REQ is a protocol error and is ignored.
- **Memory write.** Issued in a cycle where all of these hold: `sync_i`=1, output buffer occupied, `page_valid`=1, `pgend_o`=0, link FSM in IDLE.
  - That cycle: `we_o`=1, `q_o`=buffer, `addr_o`={`cur_page`,`line`}.
  - The buffer frees in the same cycle and `line` increments.
  - If `line` was `g_lines_per_page`-1, `line` wraps to 0 and `pgend_o` sets.
- **Page end.** `pgend_o` clears on the next `pgreq_i`. A `pgreq_i` arriving in the same cycle as the last-line write wins: `pgend_o` stays 0.
- **Packet boundary.** After a flushed line is written, the next line of a new packet is written only after a `pgreq_i` with `pckstart_i`=1. The block does not enforce this; it is the upstream's duty.

## Timing
- **Reset values.** All outputs are 0 at reset, including `q_o`, `addr_o`, `ll_*` and `valid_cnt_o`. `cnt`, `line` and `page_valid` are 0.
- **Latency.** A closed line is written at the earliest qualifying `sync_i`, one or more cycles after transfer to the output buffer. Transfer is combinational-free and registered.
- **Registered outputs.** `we_o` is a one-cycle pulse; `q_o` and `addr_o` are valid only while `we_o`=1. `full_o` and `pgend_o` are registered.
- **Sustained rate.** One line per `g_ratio` cycles is sustained when `sync_i` recurs at least every `g_ratio` cycles.
- **Reset mid-operation.** Partial lines and any pending link write are discarded; the link request deasserts asynchronously.

## Configuration
- `SWC_WRITE_PUMP_VALID_CNT_EN` defined: the `valid_cnt_o` port exists and is registered with `we_o`.
  - It equals `g_ratio` for a full line, or the stored word count for a flushed line.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

## Structure
- Package `swc_wr_pump_pkg`:
  - a `f_log2` constant function;
  - a line-address typedef;
  - link FSM state enum constants.
- Sub-module `swc_wr_pump_ll_ctrl`: the link FSM and its handshake. The top level holds the packing, buffering and page/line logic.

## Test plan
Defaults are used unless stated; `sync_i` pulses every 16 cycles.
- **Full line.** `pgreq_i` with `pckstart_i`=1 and page 3, then 16 words 1..16 -> one `we_o` with `addr_o`=3·8+0=24 and `q_o` word k = k+1.
- **Flush.** After 5 words, `flush_i`+`drdy_i` with word 6 -> line holds 1..6, upper 10 slots are 0; with the macro, `valid_cnt_o`=6.
- **Back-pressure.** Hold `sync_i` low while driving 40 words -> `full_o`=1 after word 32 and the next word is stalled. One `sync_i` -> a single write, then `full_o` drops the next cycle.
- **Page end.** 8 lines into page 3 -> `pgend_o`=1 after the line at `addr_o`=31; the 9th line stalls. `pgreq_i` with page 7 and `pckstart_i`=0 -> `ll_addr_o`=3, `ll_data_o`=7, request held across a 4-cycle-late `ll_wr_done_i`; the next write goes to `addr_o`=56.
- **Reset.** Assert `rst_n_i` low mid-line and during link REQ -> all outputs are 0 immediately. After release, the first write needs a fresh `pgreq_i`.
